// File: rtl/echo_pkg.sv
// Shared definitions for the stereo echo: sequencer state encoding,
// gain scaling constants and a width-parametrised saturation helper.
package echo_pkg;

    typedef enum logic [3:0] {
        CLEAR,
        IDLE,
        RD_L,
        CAP_L,
        WR_L,
        RD_R,
        CAP_R,
        WR_R,
        OUT
    } state_e;

    localparam int FB_SHIFT = 4;
    localparam int MIX_MAX  = 16;

    // Clamps a sign-extended value into the signed range of `width` bits.
    function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/echo_ram.sv
// Single-port synchronous delay-line RAM with a registered read port
// (one cycle of read latency); read-during-write returns the old word.
module echo_ram #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the array has no reset; the owner zeroes it word by word after reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stereo_echo.sv
// Stereo feedback echo: one frame per lrclk rise, both channels sharing a
// single-port delay RAM, with feedback gain, wet/dry mix and saturation.
module stereo_echo
    import echo_pkg::*;
#(
    parameter int BITSIZE    = 16,
    parameter int DEPTH_LOG2 = 14
) (
    input  logic                      bclk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      lrclk,
    input  logic [DEPTH_LOG2-1:0]     delay,
    input  logic [3:0]                feedback,
    input  logic [4:0]                mix,
    input  logic signed [BITSIZE-1:0] in_l,
    input  logic signed [BITSIZE-1:0] in_r,
    output logic signed [BITSIZE-1:0] out_l,
    output logic signed [BITSIZE-1:0] out_r,
    output logic                      busy
);

    localparam int AW = DEPTH_LOG2 + 1;
    localparam int PW = BITSIZE + 5;
    localparam int SW = BITSIZE + 1;
    localparam logic [AW-1:0] CLR_LAST  = '1;
    localparam logic [4:0]    MIX_MAX_W = 5'(MIX_MAX);

    generate
        if (BITSIZE != 16 && BITSIZE != 24) begin : g_bad_bitsize
            $error("stereo_echo: BITSIZE must be 16 or 24");
        end
    endgenerate

    function automatic logic signed [BITSIZE-1:0] wr_word(
        input logic signed [BITSIZE-1:0] x,
        input logic signed [BITSIZE-1:0] t,
        input logic [3:0]                fb
    );
        logic signed [PW-1:0] prod;
        logic signed [SW-1:0] sum;
        prod = PW'(t) * PW'($signed({1'b0, fb}));
        sum  = SW'(x) + SW'(prod >>> FB_SHIFT);
        return BITSIZE'(sat(32'(sum), BITSIZE));
    endfunction

    function automatic logic signed [BITSIZE-1:0] mix_word(
        input logic signed [BITSIZE-1:0] x,
        input logic signed [BITSIZE-1:0] t,
        input logic [4:0]                m
    );
        logic signed [PW-1:0] acc;
        logic signed [SW-1:0] scaled;
        acc    = PW'(x) * PW'($signed({1'b0, MIX_MAX_W - m}))
               + PW'(t) * PW'($signed({1'b0, m}));
        scaled = SW'(acc >>> FB_SHIFT);
        return BITSIZE'(sat(32'(scaled), BITSIZE));
    endfunction

    state_e                    state_q, state_d;
    logic                      lrclk_q;
    logic [DEPTH_LOG2-1:0]     wr_ptr_q;
    logic [DEPTH_LOG2-1:0]     rd_ptr;
    logic [AW-1:0]             clr_addr_q;
    logic signed [BITSIZE-1:0] tap_l_q, tap_r_q;
    logic signed [BITSIZE-1:0] out_l_q, out_r_q;
    logic [4:0]                mix_c;
    logic signed [BITSIZE-1:0] w_l, w_r, y_l, y_r;
    logic                      ram_we, ram_we_g;
    logic [AW-1:0]             ram_addr;
    logic [BITSIZE-1:0]        ram_wdata, ram_rdata;

    // delay = 0 lands on the slot about to be overwritten: full-depth delay.
    assign rd_ptr = wr_ptr_q - delay;
    assign mix_c  = (mix > MIX_MAX_W) ? MIX_MAX_W : mix;
    assign w_l    = enable ? wr_word(in_l, tap_l_q, feedback) : '0;
    assign w_r    = enable ? wr_word(in_r, tap_r_q, feedback) : '0;
    assign y_l    = enable ? mix_word(in_l, tap_l_q, mix_c) : in_l;
    assign y_r    = enable ? mix_word(in_r, tap_r_q, mix_c) : in_r;

    always_ff @(posedge bclk) begin
        if (reset) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR:   if (clr_addr_q == CLR_LAST) state_d = IDLE;
            IDLE:    if (lrclk && !lrclk_q) state_d = RD_L;
            RD_L:    state_d = CAP_L;
            CAP_L:   state_d = WR_L;
            WR_L:    state_d = RD_R;
            RD_R:    state_d = CAP_R;
            CAP_R:   state_d = WR_R;
            WR_R:    state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {wr_ptr_q, 1'b0};
        ram_wdata = '0;
        unique case (state_q)
            CLEAR: begin
                busy     = 1'b1;
                ram_we   = 1'b1;
                ram_addr = clr_addr_q;
            end
            RD_L: ram_addr = {rd_ptr, 1'b0};
            WR_L: begin
                ram_we    = 1'b1;
                ram_wdata = w_l;
            end
            RD_R: ram_addr = {rd_ptr, 1'b1};
            WR_R: begin
                ram_we    = 1'b1;
                ram_addr  = {wr_ptr_q, 1'b1};
                ram_wdata = w_r;
            end
            default: ;
        endcase
    end

    // NOTE: reset is synchronous, so it must also gate the RAM write that
    // would otherwise land on the same edge that aborts the sequence.
    assign ram_we_g = ram_we && !reset;

    always_ff @(posedge bclk) begin
        if (reset) begin
            lrclk_q    <= 1'b0;
            wr_ptr_q   <= '0;
            clr_addr_q <= '0;
            tap_l_q    <= '0;
            tap_r_q    <= '0;
            out_l_q    <= '0;
            out_r_q    <= '0;
        end else begin
            lrclk_q <= lrclk;
            if (state_q == CLEAR) clr_addr_q <= clr_addr_q + 1'b1;
            if (state_q == CAP_L) tap_l_q <= ram_rdata;
            if (state_q == CAP_R) tap_r_q <= ram_rdata;
            if (state_q == OUT) begin
                out_l_q  <= y_l;
                out_r_q  <= y_r;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
        end
    end

    assign out_l = out_l_q;
    assign out_r = out_r_q;

    echo_ram #(
        .WIDTH  (BITSIZE),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (bclk),
        .we_i    (ram_we_g),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_stereo_echo.sv
// Self-checking bench for stereo_echo: directed vector table, corner-case
// sequences and randomized frames against an array-based echo model.
module tb_stereo_echo;

    localparam int BITSIZE    = 16;
    localparam int DEPTH_LOG2 = 4;
    localparam int FRAMES     = 1 << DEPTH_LOG2;
    localparam int CLEAR_LEN  = 2 * FRAMES;

    logic                      bclk = 1'b0;
    logic                      reset;
    logic                      enable;
    logic                      lrclk;
    logic [DEPTH_LOG2-1:0]     delay;
    logic [3:0]                feedback;
    logic [4:0]                mix;
    logic signed [BITSIZE-1:0] in_l, in_r;
    logic signed [BITSIZE-1:0] out_l, out_r;
    logic                      busy;

    int n_checks = 0;
    int n_pass   = 0;

    int mem_m [2][FRAMES];
    int wp_m;

    typedef struct {
        int rst;
        int en;
        int dly;
        int fb;
        int mx;
        int il;
        int ir;
        int el;
        int er;
    } vec_t;

    vec_t vecs[$];

    stereo_echo #(
        .BITSIZE    (BITSIZE),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .bclk     (bclk),
        .reset    (reset),
        .enable   (enable),
        .lrclk    (lrclk),
        .delay    (delay),
        .feedback (feedback),
        .mix      (mix),
        .in_l     (in_l),
        .in_r     (in_r),
        .out_l    (out_l),
        .out_r    (out_r),
        .busy     (busy)
    );

    always #5 bclk = ~bclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int sat16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < FRAMES; i++) mem_m[c][i] = 0;
        wp_m = 0;
    endtask

    // Echo semantics: tap = word stored `delay` frames ago (0 -> FRAMES ago).
    task automatic model_frame(input int en, input int dly, input int fb, input int mx,
                               input int il, input int ir, output int yl, output int yr);
        int ins [2];
        int ys  [2];
        int m;
        int d;
        ins[0] = il;
        ins[1] = ir;
        m = (mx > 16) ? 16 : mx;
        d = (dly == 0) ? FRAMES : dly;
        for (int ch = 0; ch < 2; ch++) begin
            int tap;
            tap = mem_m[ch][(wp_m - d + FRAMES) % FRAMES];
            if (en != 0) begin
                ys[ch] = sat16((ins[ch] * (16 - m) + tap * m) >>> 4);
                mem_m[ch][wp_m] = sat16(ins[ch] + ((tap * fb) >>> 4));
            end else begin
                ys[ch] = ins[ch];
                mem_m[ch][wp_m] = 0;
            end
        end
        wp_m = (wp_m + 1) % FRAMES;
        yl = ys[0];
        yr = ys[1];
    endtask

    task automatic add_vec(input int rst, input int en, input int dly, input int fb, input int mx,
                           input int il, input int ir, input int el, input int er);
        vec_t v;
        v.rst = rst; v.en = en; v.dly = dly; v.fb = fb; v.mx = mx;
        v.il = il; v.ir = ir; v.el = el; v.er = er;
        vecs.push_back(v);
    endtask

    // One 64-cycle lrclk period; returns on a negedge after OUT has settled.
    task automatic run_frame(input int en, input int dly, input int fb, input int mx,
                             input int il, input int ir);
        @(negedge bclk);
        enable   = (en != 0);
        delay    = 4'(dly);
        feedback = 4'(fb);
        mix      = 5'(mx);
        in_l     = 16'(il);
        in_r     = 16'(ir);
        lrclk    = 1'b1;
        repeat (32) @(negedge bclk);
        lrclk = 1'b0;
        repeat (31) @(negedge bclk);
    endtask

    // Called on the negedge where reset was just released.
    task automatic count_clear(input bit toggle);
        int n;
        bit quiet;
        n = 0;
        quiet = 1'b1;
        while (busy === 1'b1 && n < 1000) begin
            if (out_l !== 16'sd0 || out_r !== 16'sd0) quiet = 1'b0;
            if (toggle) lrclk = (n < 24) ? n[1] : 1'b0;
            n++;
            @(negedge bclk);
        end
        check("clear_cycles", n, CLEAR_LEN);
        if (toggle) check("quiet_during_clear", int'(quiet), 1);
        check("post_clear_out_l", out_l, 0);
        check("post_clear_out_r", out_r, 0);
        model_reset();
    endtask

    task automatic do_reset(input bit toggle);
        @(negedge bclk);
        reset = 1'b1;
        lrclk = 1'b0;
        repeat (3) @(negedge bclk);
        check("reset_busy", busy, 1);
        check("reset_out_l", out_l, 0);
        check("reset_out_r", out_r, 0);
        reset = 1'b0;
        count_clear(toggle);
    endtask

    initial begin
        int yl, yr;
        reset = 1'b1; enable = 1'b1; lrclk = 1'b0; delay = '0;
        feedback = '0; mix = '0; in_l = '0; in_r = '0;

        // Impulse: delay 4, feedback 1/2, fully wet.
        for (int f = 0; f <= 12; f++)
            add_vec((f == 0) ? 1 : 0, 1, 4, 8, 16, (f == 0) ? 1000 : 0, 0,
                    (f == 4) ? 1000 : (f == 8) ? 500 : (f == 12) ? 250 : 0, 0);
        // Saturation at both rails, delay 1, feedback 15/16, half mix.
        add_vec(1, 1, 1, 15, 8, 32767, -32768, 16383, -16384);
        add_vec(0, 1, 1, 15, 8, 32767, -32768, 32767, -32768);
        add_vec(0, 1, 1, 15, 8, 32767, -32768, 32767, -32768);
        // Bypass passes dry input and flushes the delay line.
        add_vec(1, 1, 2, 8, 16, 500, 0, 0, 0);
        for (int f = 0; f < 3; f++) add_vec(0, 0, 2, 8, 16, 7, -9, 7, -9);
        add_vec(0, 1, 2, 8, 16, 0, 0, 0, 0);
        add_vec(0, 1, 2, 8, 16, 0, 0, 0, 0);
        // Delay 1 echoes on the very next frame.
        add_vec(1, 1, 1, 0, 16, 200, -300, 0, 0);
        add_vec(0, 1, 1, 0, 16, 0, 0, 200, -300);
        add_vec(0, 1, 1, 0, 16, 0, 0, 0, 0);

        in_l = 16'sd1234;
        in_r = -16'sd1234;
        do_reset(1'b1);
        in_l = '0;
        in_r = '0;

        foreach (vecs[i]) begin
            if (vecs[i].rst != 0) do_reset(1'b0);
            run_frame(vecs[i].en, vecs[i].dly, vecs[i].fb, vecs[i].mx, vecs[i].il, vecs[i].ir);
            check($sformatf("vec%0d_l", i), out_l, vecs[i].el);
            check($sformatf("vec%0d_r", i), out_r, vecs[i].er);
        end

        // delay 0 = full depth, echo arrives after the write pointer wraps.
        do_reset(1'b0);
        run_frame(1, 0, 0, 16, 777, -777);
        check("d0_frame0_l", out_l, 0);
        for (int f = 1; f <= FRAMES; f++) begin
            run_frame(1, 0, 0, 16, 0, 0);
            if (f == FRAMES - 1) check("d0_early_l", out_l, 0);
            if (f == FRAMES) begin
                check("d0_echo_l", out_l, 777);
                check("d0_echo_r", out_r, -777);
            end
        end

        // Randomized frames against the model.
        do_reset(1'b0);
        for (int k = 0; k < 200; k++) begin
            int en, dly, fb, mx, il, ir, sel;
            en  = ($urandom_range(0, 7) != 0) ? 1 : 0;
            dly = $urandom_range(0, FRAMES - 1);
            fb  = $urandom_range(0, 15);
            mx  = $urandom_range(0, 31);
            sel = $urandom_range(0, 7);
            il  = (sel == 0) ? 32767 : (sel == 1) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
            sel = $urandom_range(0, 7);
            ir  = (sel == 0) ? 32767 : (sel == 1) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
            run_frame(en, dly, fb, mx, il, ir);
            model_frame(en, dly, fb, mx, il, ir, yl, yr);
            check($sformatf("rnd%0d_l", k), out_l, yl);
            check($sformatf("rnd%0d_r", k), out_r, yr);
        end

        // Reset landing on WR_L aborts the frame and restarts the clear.
        do_reset(1'b0);
        run_frame(1, 1, 0, 0, 100, -100);
        check("mf_pre_l", out_l, 100);
        check("mf_pre_r", out_r, -100);
        @(negedge bclk);
        in_l = 16'sd555;
        in_r = 16'sd555;
        lrclk = 1'b1;
        @(posedge bclk);
        @(posedge bclk);
        @(posedge bclk);
        @(negedge bclk);
        reset = 1'b1;
        @(posedge bclk);
        #1;
        check("mf_out_l", out_l, 0);
        check("mf_out_r", out_r, 0);
        check("mf_busy", busy, 1);
        @(negedge bclk);
        lrclk = 1'b0;
        @(negedge bclk);
        reset = 1'b0;
        count_clear(1'b0);
        for (int f = 0; f < 3; f++) begin
            run_frame(1, 1, 8, 16, (f == 0) ? 300 : 0, (f == 0) ? -300 : 0);
            model_frame(1, 1, 8, 16, (f == 0) ? 300 : 0, (f == 0) ? -300 : 0, yl, yr);
            check($sformatf("mf_post%0d_l", f), out_l, yl);
            check($sformatf("mf_post%0d_r", f), out_r, yr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stereo_echo.md
# stereo_echo

Stereo feedback echo for the audio path: per-channel delayed tap from one shared single-port RAM, programmable delay, feedback gain and wet/dry mix, saturating arithmetic, and a hardware memory clear after reset. Sits between the I2S receiver and transmitter in the `bclk` domain and replaces the mono, fixed-mix echo. Supports 16- and 24-bit samples.

## Interface
- `BITSIZE`, 16: sample width; only 16 or 24 are legal, any other value is an elaboration error.
- `DEPTH_LOG2`, 14: maximum delay is 2^DEPTH_LOG2 frames per channel; RAM holds 2^(DEPTH_LOG2+1) words of BITSIZE.

Ports:
- `bclk` in 1: sole clock, 64 × lrclk.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: 0 = bypass (dry only).
- `lrclk` in 1: frame clock, synchronous to `bclk`.
- `delay` in DEPTH_LOG2: delay in frames; 0 means 2^DEPTH_LOG2.
- `feedback` in 4: feedback gain, feedback/16 (0..15/16).
- `mix` in 5: wet fraction mix/16; values above 16 are clamped to 16.
- `in_l`, `in_r` in BITSIZE signed: input samples.
- `out_l`, `out_r` out BITSIZE signed: processed samples.
- `busy` out 1: high while the memory clear runs.

## Operation
- States: CLEAR, IDLE, RD_L, CAP_L, WR_L, RD_R, CAP_R, WR_R, OUT.
- Reset: state CLEAR, `wr_ptr`=0, clear address=0, `out_l`=`out_r`=0, `busy`=1.
- CLEAR writes 0 to one RAM word per cycle, address 0 to 2^(DEPTH_LOG2+1)−1. It then goes to IDLE and drops `busy` on the following cycle. lrclk edges are ignored during CLEAR.
- IDLE detects a rising edge of `lrclk` (registered previous value 0, current value 1), then runs RD_L→CAP_L→WR_L→RD_R→CAP_R→WR_R→OUT→IDLE, one cycle each.
- RAM address = {ptr, ch}, with ch=0 for L and ch=1 for R.
- Read pointer = (wr_ptr − delay) mod 2^DEPTH_LOG2. A `delay` of 0 therefore reads the slot about to be overwritten, giving the full-depth delay.
- RD_x presents the read address. CAP_x registers the tap (1-cycle RAM latency). WR_x writes w = sat(in_x + ((tap_x × feedback) >>> 4)) at {wr_ptr, ch}.
- Products are signed, BITSIZE+5 bits wide. Sums use BITSIZE+1 bits. `sat` clamps to [−2^(BITSIZE−1), 2^(BITSIZE−1)−1].
- Output: y_x = sat(((in_x × (16−m)) + (tap_x × m)) >>> 4), where m is `mix` clamped to 16. Arithmetic shift, truncation toward −∞.
- If `enable`=0: y_x = in_x, and the RAM write value is 0, so the tail is flushed and no stale echo appears on re-enable.
- OUT registers `out_l`/`out_r` from y_l/y_r and increments `wr_ptr`, wrapping from 2^DEPTH_LOG2−1 to 0.
- `in_l`, `in_r`, `delay`, `feedback`, `mix` and `enable` are sampled in the sequence cycle that uses them. They must be stable from RD_L through OUT; changes take effect on the next frame.
- An lrclk rising edge outside IDLE is ignored; that frame is dropped and outputs hold.
- Reset asserted in any state aborts the sequence, including a pending RAM write, and restarts CLEAR.

## Timing
- Edge detected in cycle E (the IDLE cycle sampling lrclk=1 with previous value 0).
- RD_L=E+1, WR_L=E+3, WR_R=E+6, OUT=E+7. New outputs are visible from E+8 and held until the next OUT.
- Throughput: one stereo frame per lrclk period. The 8-cycle sequence fits easily in 64 cycles.
- Echo latency: an input at frame n first appears in the tap at frame n+delay.
- Clear takes 2^(DEPTH_LOG2+1) cycles after reset release; `busy` falls one cycle after the last clear write.

## Structure
- Shared package `echo_pkg`:
  - state encoding,
  - FB_SHIFT=4 and MIX_MAX=16,
  - the `sat` function parametrised by width.
- Sub-module `echo_ram`: single-port synchronous RAM, BITSIZE × 2^(DEPTH_LOG2+1), registered read with 1-cycle latency, write-enable input, no read-during-write guarantee required.

## Test plan
- Reset, then idle: `busy`=1 for exactly 2^(DEPTH_LOG2+1) cycles and outputs stay 0; any lrclk edges during clear produce no output change.
- Single impulse: `in_l`=1000 at frame 0 and 0 after; delay=4, feedback=8, mix=16. Required `out_l`: 1000 at frame 4, 500 at frame 8, 250 at frame 12; `out_r` stays 0 throughout.
- Saturation: in=32767, tap=32767, feedback=15, BITSIZE=16. The stored value clamps to 32767; mix=8 gives 32767, not a wrap to a negative value.
- Delay boundaries:
  - delay=0 gives the echo at frame 2^DEPTH_LOG2.
  - delay=1 gives the echo the next frame.
  - The result is correct across `wr_ptr` wrap.
- Bypass flush: enable=0 gives out=in at E+8. After re-enable following ≥delay frames, no residual echo appears.
- Reset asserted at WR_L mid-frame: no RAM write occurs, CLEAR restarts with `wr_ptr`=0, and outputs go to 0 on the next cycle.
